// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// alu_arbiter: shares one 32-bit ALU between two requesters, holding each response until consumed.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [5*N_REQ-1:0]    req_aluc,
    output logic [N_REQ-1:0]      rsp_valid,
    input  logic [N_REQ-1:0]      rsp_ready,
    output logic [31:0]           rsp_result,
    output logic [3:0]            rsp_flags,
    output logic                  rsp_err,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [4:0]            alu_aluc,
    input  logic [31:0]           alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    input  logic                  alu_negative,
    input  logic                  alu_overflow,
    output logic                  busy
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] EXEC     = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;
    localparam logic [4:0] ALUC_MAX = 5'b10000;

    logic [1:0]  state;
    logic        owner;
    logic        pend_err;
    logic        consume;
    logic        grant_en;
    logic        grant_id;
    logic        tie_pick;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [4:0]  sel_aluc;
    logic        sel_illegal;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign tie_pick = 1'b0;
`else
    // Priority pointer: after a grant to i, the other requester wins the next tie.
    logic ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (grant_en) begin
            ptr <= ~grant_id;
        end
    end

    assign tie_pick = ptr;
`endif

    assign grant_id    = (&req_valid) ? tie_pick : req_valid[1];
    assign consume     = (state == DONE) && rsp_ready[owner];
    assign grant_en    = rst_n && (|req_valid) && ((state == IDLE) || consume);
    assign req_ready   = {grant_en & grant_id, grant_en & ~grant_id};

    assign sel_a       = grant_id ? req_a[63:32]   : req_a[31:0];
    assign sel_b       = grant_id ? req_b[63:32]   : req_b[31:0];
    assign sel_aluc    = grant_id ? req_aluc[9:5]  : req_aluc[4:0];
    assign sel_illegal = sel_aluc > ALUC_MAX;

    assign busy        = (state != IDLE);

    // Illegal opcodes still take the EXEC slot but leave the ALU operands untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            pend_err   <= 1'b0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_aluc   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (consume) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                    if (grant_en) begin
                        state    <= EXEC;
                        owner    <= grant_id;
                        pend_err <= sel_illegal;
                        if (!sel_illegal) begin
                            alu_a    <= sel_a;
                            alu_b    <= sel_b;
                            alu_aluc <= sel_aluc;
                        end
                    end
                end
                EXEC: begin
                    state      <= DONE;
                    rsp_valid  <= {owner, ~owner};
                    rsp_err    <= pend_err;
                    rsp_result <= pend_err ? 32'd0 : alu_result;
                    rsp_flags  <= pend_err ? 4'd0
                                           : {alu_zero, alu_carry, alu_negative, alu_overflow};
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for alu_arbiter: expected responses are queued at accept time and
// compared by a monitor when the granted requester consumes each response.
module tb_alu_arbiter;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  aluc;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } vec_t;

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [9:0]  req_aluc;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_aluc;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_negative;
    logic        alu_overflow;
    logic        busy;

    vec_t vq0[$];
    vec_t vq1[$];
    exp_t exp_q[$];
    int   grant_log[$];
    int   grant_cyc[$];
    vec_t cur0;
    vec_t cur1;
    bit   acc0 = 0;
    bit   acc1 = 0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    bit          hold_on = 0;
    logic [1:0]  held_valid;
    logic [31:0] held_res;
    logic [3:0]  held_flg;
    logic        held_err;

    alu_arbiter #(.N_REQ(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_aluc     (req_aluc),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_err      (rsp_err),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_aluc     (alu_aluc),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Lab ALU: unsigned ops report carry/borrow on OverFlow as well.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum      = 33'd0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_aluc)
            5'b00000: begin
                alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry    = alu_sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            5'b00001: begin
                alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
                alu_carry    = alu_sum[32];
                alu_overflow = alu_sum[32];
            end
            5'b00010: begin
                alu_sum      = {1'b0, alu_a - alu_b};
                alu_carry    = alu_a < alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
            end
            5'b00011: begin
                alu_sum      = {1'b0, alu_a - alu_b};
                alu_carry    = alu_a < alu_b;
                alu_overflow = alu_a < alu_b;
            end
            5'b00100: alu_sum = {1'b0, alu_a & alu_b};
            5'b00101: alu_sum = {1'b0, alu_a | alu_b};
            default:  alu_sum = 33'd0;
        endcase
        alu_result   = alu_sum[31:0];
        alu_zero     = (alu_sum[31:0] == 32'd0);
        alu_negative = alu_sum[31];
    end

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [4:0] aluc,
                                logic [31:0] res, logic [3:0] flg, logic err);
        vec_t v;
        v.a = a; v.b = b; v.aluc = aluc; v.res = res; v.flg = flg; v.err = err;
        return v;
    endfunction

    task automatic check_output(string nm, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    task automatic report_timeout(string nm);
        n_vec++;
        n_bad++;
        $display("[TB] FAIL %s: timed out waiting on the DUT", nm);
    endtask

    task automatic apply_stimulus(int who, vec_t v);
        if (who == 0) vq0.push_back(v);
        else          vq1.push_back(v);
    endtask

    task automatic wait_accept(int who, int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (req_valid[who] && req_ready[who]) return;
        end
        report_timeout("wait_accept");
    endtask

    task automatic wait_drain(int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (vq0.size() == 0 && vq1.size() == 0 && req_valid == 2'b00 &&
                exp_q.size() == 0 && !busy) return;
        end
        report_timeout("wait_drain");
    endtask

    // Requester drivers: present queued vectors, drop valid after each accept edge.
    initial begin
        req_valid = 2'b00;
        req_a     = 64'd0;
        req_b     = 64'd0;
        req_aluc  = 10'd0;
        forever begin
            @(posedge clk);
            #1;
            if (acc0) begin acc0 = 0; req_valid[0] = 1'b0; end
            if (acc1) begin acc1 = 0; req_valid[1] = 1'b0; end
            if (!req_valid[0] && vq0.size() > 0) begin
                cur0 = vq0.pop_front();
                req_a[31:0] = cur0.a; req_b[31:0] = cur0.b; req_aluc[4:0] = cur0.aluc;
                req_valid[0] = 1'b1;
            end
            if (!req_valid[1] && vq1.size() > 0) begin
                cur1 = vq1.pop_front();
                req_a[63:32] = cur1.a; req_b[63:32] = cur1.b; req_aluc[9:5] = cur1.aluc;
                req_valid[1] = 1'b1;
            end
        end
    end

    // Accept observer: queue the expected response for each granted vector.
    always @(negedge clk) begin
        if (req_valid[0] && req_ready[0]) begin
            acc0 = 1;
            exp_q.push_back('{0, cur0.res, cur0.flg, cur0.err});
            grant_log.push_back(0);
            grant_cyc.push_back(cyc);
        end
        if (req_valid[1] && req_ready[1]) begin
            acc1 = 1;
            exp_q.push_back('{1, cur1.res, cur1.flg, cur1.err});
            grant_log.push_back(1);
            grant_cyc.push_back(cyc);
        end
    end

    // Monitor: response must hold steady while stalled and match the scoreboard on consume.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || rsp_valid == 2'b00) begin
            hold_on = 0;
        end else begin
            if (hold_on) begin
                check_output("hold_valid",  {30'd0, rsp_valid}, {30'd0, held_valid});
                check_output("hold_result", rsp_result, held_res);
                check_output("hold_flags",  {28'd0, rsp_flags}, {28'd0, held_flg});
                check_output("hold_err",    {31'd0, rsp_err}, {31'd0, held_err});
            end
            if ((rsp_valid & rsp_ready) != 2'b00) begin
                hold_on = 0;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("[TB] FAIL rsp_unexpected: got valid %b, expected no response", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    check_output("rsp_valid",  {30'd0, rsp_valid}, (e.owner == 1) ? 32'd2 : 32'd1);
                    check_output("rsp_result", rsp_result, e.res);
                    check_output("rsp_flags",  {28'd0, rsp_flags}, {28'd0, e.flg});
                    check_output("rsp_err",    {31'd0, rsp_err}, {31'd0, e.err});
                end
            end else begin
                hold_on    = 1;
                held_valid = rsp_valid;
                held_res   = rsp_result;
                held_flg   = rsp_flags;
                held_err   = rsp_err;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        rsp_ready = 2'b11;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_busy",      {31'd0, busy}, 32'd0);
        check_output("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check_output("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_output("rst_alu_a",     alu_a, 32'd0);
        check_output("rst_alu_aluc",  {27'd0, alu_aluc}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single op with latency: ADDU 5+7
        apply_stimulus(0, mk(32'd5, 32'd7, 5'b00001, 32'd12, 4'b0000, 1'b0));
        wait_accept(0, 20);
        @(posedge clk);
        @(negedge clk);
        check_output("exec_busy",   {31'd0, busy}, 32'd1);
        check_output("exec_no_rsp", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check_output("latency_valid", {30'd0, rsp_valid}, 32'd1);
        wait_drain(50);

        // Flags: SUBU 0-1 from requester 1
        apply_stimulus(1, mk(32'd0, 32'd1, 5'b00011, 32'hFFFF_FFFF, 4'b0111, 1'b0));
        wait_drain(50);

        // Illegal opcode after an ADD: ALU registers keep the ADD operands
        apply_stimulus(0, mk(32'd3, 32'd4, 5'b00000, 32'd7, 4'b0000, 1'b0));
        apply_stimulus(0, mk(32'd99, 32'd1, 5'b10001, 32'd0, 4'b0000, 1'b1));
        wait_drain(50);
        check_output("illegal_alu_aluc", {27'd0, alu_aluc}, 32'd0);
        check_output("illegal_alu_a",    alu_a, 32'd3);
        check_output("illegal_alu_b",    alu_b, 32'd4);

        // Backpressure on requester 0 while requester 1 waits
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        apply_stimulus(0, mk(32'hF0F0_00FF, 32'h0FF0_0F0F, 5'b00100, 32'h00F0_000F, 4'b0000, 1'b0));
        wait_accept(0, 20);
        apply_stimulus(1, mk(32'h8000_0000, 32'h0000_0001, 5'b00101, 32'h8000_0001, 4'b0010, 1'b0));
        for (int k = 0; k < 20 && rsp_valid[0] !== 1'b1; k++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check_output("stall_req_ready", {30'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        check_output("release_grant", {30'd0, req_ready}, 32'd2);
        wait_drain(50);

        // Contention from reset: both requesters valid continuously
        @(posedge clk); #1;
        rst_n = 1'b0;
        apply_stimulus(0, mk(32'd5, 32'd7, 5'b00001, 32'd12, 4'b0000, 1'b0));
        apply_stimulus(1, mk(32'd0, 32'd1, 5'b00011, 32'hFFFF_FFFF, 4'b0111, 1'b0));
        apply_stimulus(0, mk(32'd0, 32'hFFFF_FFFF, 5'b00000, 32'hFFFF_FFFF, 4'b0010, 1'b0));
        apply_stimulus(1, mk(32'd1, 32'hFFFF_FFFF, 5'b00001, 32'd0, 4'b1101, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        base  = grant_log.size();
        rst_n = 1'b1;
        wait_drain(100);
        if (grant_log.size() < base + 4) begin
            report_timeout("contention_grants");
        end else begin
            for (int k = 0; k < 4; k++)
                check_output("contention_order", grant_log[base+k], k % 2);
            for (int k = 1; k < 4; k++)
                check_output("contention_gap", grant_cyc[base+k] - grant_cyc[base+k-1], 32'd2);
        end

        // Reset during EXEC discards the op and re-arms requester 0 priority
        apply_stimulus(0, mk(32'd2, 32'd2, 5'b00001, 32'd4, 4'b0000, 1'b0));
        wait_accept(0, 20);
        @(posedge clk); #1;
        rst_n = 1'b0;
        apply_stimulus(0, mk(32'd10, 32'd3, 5'b00010, 32'd7, 4'b0000, 1'b0));
        apply_stimulus(1, mk(32'd8, 32'd8, 5'b00001, 32'd16, 4'b0000, 1'b0));
        @(posedge clk);
        @(negedge clk);
        check_output("midrst_busy",      {31'd0, busy}, 32'd0);
        check_output("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_output("midrst_alu_a",     alu_a, 32'd0);
        check_output("midrst_req_ready", {30'd0, req_ready}, 32'd0);
        exp_q.delete();
        base = grant_log.size();
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_drain(100);
        if (grant_log.size() < base + 2) begin
            report_timeout("midrst_grants");
        end else begin
            check_output("midrst_first_grant",  grant_log[base],   32'd0);
            check_output("midrst_second_grant", grant_log[base+1], 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
